bpu_update_queue: RTL
=====================

BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of in-flight prediction-metadata entries (power of two, 2..16).
REQ-002 CLK  in  1  SHALL be the clock; all state SHALL update on posedge CLK.
REQ-003 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 BPU__Stall  in  1  SHALL be the global BPU stall; when high, queue state and all outputs are frozen.
REQ-005 Push_Valid  in  1  SHALL mean fetch issued a direction prediction to record.
REQ-006 Push_Index  in  11  SHALL be the PHT index used for that prediction.
REQ-007 Push_Counter  in  2  SHALL be the PHT counter read for that prediction.
REQ-008 Push_Ready  out  1  SHALL mean the queue is not full (combinational).
REQ-009 Resolve_Valid  in  1  SHALL mean execute resolved the oldest outstanding branch.
REQ-010 Resolve_Taken  in  1  SHALL be that branch's actual outcome.
REQ-011 Resolve_Ready  out  1  SHALL equal (queue not empty) AND NOT BPU__Stall (combinational).
REQ-012 Flush  in  1  SHALL discard all outstanding entries (pipeline redirect).
REQ-013 PHT_Write_Index  out  11; PHT_Write_Data  out  2; PHT_Write_En  out  1  SHALL feed the direction predictor PHT write port.
REQ-014 GHR_Write_Data  out  1; GHR_Write_En  out  1  SHALL feed the predictor GHR shift.
REQ-015 Mispredict  out  1  SHALL flag that the resolved outcome differed from the stored prediction.
REQ-016 Occupancy  out  log2(DEPTH)+1  SHALL report the current entry count.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries, each {Index[10:0], Counter[1:0]}; read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from an extra pointer MSB.
REQ-018 Push SHALL occur when Push_Valid & Push_Ready & ~BPU__Stall & ~Flush.
REQ-019 Pop SHALL occur when Resolve_Valid & Resolve_Ready; Resolve_Valid while empty or stalled SHALL be ignored with no output change.
REQ-020 When full, Push_Ready SHALL be 0 even if a pop occurs in the same cycle (no full-bypass).
REQ-021 Simultaneous push and pop when not full and not empty SHALL leave Occupancy unchanged.
REQ-022 On pop, next counter SHALL be 2-bit saturating: taken -> min(C+1,3); not taken -> max(C-1,0); C is the stored Counter of the head entry.
REQ-023 Output latency SHALL be one cycle: in the cycle after a pop, PHT_Write_En=1, PHT_Write_Index=head Index, PHT_Write_Data=next counter, GHR_Write_En=1, GHR_Write_Data=Resolve_Taken, Mispredict=(C[1] != Resolve_Taken).
REQ-024 PHT_Write_En, GHR_Write_En and Mispredict SHALL be single-cycle pulses per pop; after a non-stalled cycle without a pop they SHALL be 0, and Index/Data outputs SHALL hold their last values.
REQ-025 While BPU__Stall=1, all registered outputs, pointers and entries SHALL hold, so a pending write pulse stays asserted until the first unstalled cycle and is consumed exactly once.
REQ-026 Flush SHALL set Occupancy to 0 at the next edge regardless of BPU__Stall; a pop in the same cycle SHALL still produce its update (the resolved branch is older than the redirect); a same-cycle push SHALL be discarded.
REQ-027 Entry contents SHALL never be modified after push; updates SHALL use the stored counter, not a re-read PHT value.

Reset
REQ-028 RST=1 SHALL clear both pointers (Occupancy=0), PHT_Write_Index=0, PHT_Write_Data=0, PHT_Write_En=0, GHR_Write_Data=0, GHR_Write_En=0, Mispredict=0; RST SHALL override Stall and Flush.
REQ-029 During RST, Push_Ready=1 and Resolve_Ready=0; entry storage need not be cleared.

Verification
REQ-030 Push {0x155, 2'b01}, resolve taken -> next cycle PHT_Write_En=1, Index=0x155, Data=2'b10, GHR_Write_Data=1, Mispredict=1.
REQ-031 Saturation: push {0x010,3} resolve taken -> Data=3, Mispredict=0; push {0x011,0} resolve not taken -> Data=0, Mispredict=0.
REQ-032 Fill 8 entries -> Push_Ready=0, Occupancy=8; push+pop same cycle -> push rejected, Occupancy=7; 16 further push/pop pairs -> outputs in FIFO order across pointer wrap.
REQ-033 Pop then BPU__Stall=1 for 3 cycles -> PHT_Write_En stays 1 and outputs frozen through stall, drops to 0 one cycle after stall release; Resolve_Ready=0 during stall.
REQ-034 Occupancy=5, Flush with same-cycle pop and push -> one write pulse for popped entry, Occupancy=0, pushed entry absent; Resolve_Valid next cycle ignored.
REQ-035 RST asserted mid-operation with Occupancy=4 and pending write pulse -> next cycle all outputs 0, Occupancy=0, Resolve_Ready=0.

Source files
------------

// File: rtl/bpu_update_queue.sv
// Branch predictor update queue.
// Records the PHT index and counter used for each direction prediction. When
// execute resolves the oldest outstanding branch, the stored counter is
// advanced with 2-bit saturation and emitted as a one-cycle PHT/GHR write
// pulse on the following cycle.
module bpu_update_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     BPU__Stall,
  input  logic                     Push_Valid,
  input  logic [10:0]              Push_Index,
  input  logic [1:0]               Push_Counter,
  output logic                     Push_Ready,
  input  logic                     Resolve_Valid,
  input  logic                     Resolve_Taken,
  output logic                     Resolve_Ready,
  input  logic                     Flush,
  output logic [10:0]              PHT_Write_Index,
  output logic [1:0]               PHT_Write_Data,
  output logic                     PHT_Write_En,
  output logic                     GHR_Write_Data,
  output logic                     GHR_Write_En,
  output logic                     Mispredict,
  output logic [$clog2(DEPTH):0]   Occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [AW:0] wptr, rptr;
  logic [10:0] mem_idx [DEPTH];
  logic [1:0]  mem_cnt [DEPTH];

  logic        full, empty, push, pop;
  logic [10:0] head_idx;
  logic [1:0]  head_cnt, next_cnt;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  // Ready flags are forced to their reset-time values while RST is high,
  // since the pointers are only cleared at the next edge.
  assign Push_Ready    = RST | ~full;
  assign Resolve_Ready = ~RST & ~empty & ~BPU__Stall;

  // Full uses the pre-pop state: a same-cycle pop never makes room for a push.
  assign push = Push_Valid & Push_Ready & ~BPU__Stall & ~Flush & ~RST;
  assign pop  = Resolve_Valid & Resolve_Ready;

  assign head_idx  = mem_idx[rptr[AW-1:0]];
  assign head_cnt  = mem_cnt[rptr[AW-1:0]];
  assign Occupancy = wptr - rptr;

  // Saturating 2-bit counter update driven by the stored (not re-read) counter.
  always_comb begin
    next_cnt = head_cnt;
    if (Resolve_Taken && head_cnt != 2'd3)
      next_cnt = head_cnt + 2'd1;
    else if (!Resolve_Taken && head_cnt != 2'd0)
      next_cnt = head_cnt - 2'd1;
  end

  // Entry storage: written once on push, never modified afterwards.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_idx[wptr[AW-1:0]] <= Push_Index;
      mem_cnt[wptr[AW-1:0]] <= Push_Counter;
    end
  end

  // Pointer update; flush empties the queue even while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (Flush)
        rptr <= wptr;
      else if (pop)
        rptr <= rptr + PTR_ONE;
    end
  end

  // Registered update outputs: pulse for one unstalled cycle after each pop,
  // held unchanged through stalls so a pending pulse is seen exactly once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PHT_Write_Index <= '0;
      PHT_Write_Data  <= '0;
      PHT_Write_En    <= 1'b0;
      GHR_Write_Data  <= 1'b0;
      GHR_Write_En    <= 1'b0;
      Mispredict      <= 1'b0;
    end else if (!BPU__Stall) begin
      PHT_Write_En <= pop;
      GHR_Write_En <= pop;
      Mispredict   <= pop & (head_cnt[1] != Resolve_Taken);
      if (pop) begin
        PHT_Write_Index <= head_idx;
        PHT_Write_Data  <= next_cnt;
        GHR_Write_Data  <= Resolve_Taken;
      end
    end
  end

endmodule
